// File: rtl/mdio_master_if.sv
// Command/response handshake and MDIO pin bundle for mdio_master.
interface mdio_master_if #(
    parameter int NCHAN = 2
) ();
    localparam int CHAN_BITS = $clog2(NCHAN + 1);

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [CHAN_BITS-1:0] cmd_chan;
    logic                 cmd_c45;
    logic [1:0]           cmd_op;
    logic [4:0]           cmd_phy;
    logic [4:0]           cmd_reg;
    logic [15:0]          cmd_data;
    logic                 rsp_valid;
    logic [CHAN_BITS-1:0] rsp_chan;
    logic [15:0]          rsp_data;
    logic                 rsp_err;
    logic [NCHAN-1:0]     mdc;
    logic [NCHAN-1:0]     mdio_out;
    logic [NCHAN-1:0]     mdio_en;
    logic [NCHAN-1:0]     mdio_in;

    // Requester side: issues commands, sees responses, plays the PHY on mdio_in
    modport master (
        output cmd_valid, cmd_chan, cmd_c45, cmd_op, cmd_phy, cmd_reg, cmd_data, mdio_in,
        input  cmd_ready, rsp_valid, rsp_chan, rsp_data, rsp_err, mdc, mdio_out, mdio_en
    );

    // Controller side
    modport slave (
        input  cmd_valid, cmd_chan, cmd_c45, cmd_op, cmd_phy, cmd_reg, cmd_data, mdio_in,
        output cmd_ready, rsp_valid, rsp_chan, rsp_data, rsp_err, mdc, mdio_out, mdio_en
    );
endinterface

// File: rtl/mdio_master.sv
// Multi-bus MDIO management master: clause 22 / clause 45 frames with
// optional preamble, one command in flight, one response pulse per command.
module mdio_master #(
    parameter int HZ            = 50000000,
    parameter int MDC_HZ        = 2500000,
    parameter int NCHAN         = 2,
    parameter int PREAMBLE_BITS = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    mdio_master_if.slave bus
);
    localparam int HALF      = HZ / MDC_HZ / 2;
    localparam int CHAN_BITS = $clog2(NCHAN + 1);
    localparam int CNT_W     = $clog2(2 * HALF);
    localparam int MAX_BITS  = (PREAMBLE_BITS > 32) ? PREAMBLE_BITS : 32;
    localparam int BIT_W     = $clog2(MAX_BITS + 1);

    localparam logic [CNT_W-1:0] RISE_AT  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] END_AT   = CNT_W'(2 * HALF - 1);
    localparam logic [BIT_W-1:0] PRE_LAST = BIT_W'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);

    generate
        if (HALF < 2) begin : g_bad_half
            $error("mdio_master: HZ/MDC_HZ/2 must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, PRE, FRAME, TA_RD, DATA_RD, END} state_t;

    state_t               state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [BIT_W-1:0]     bit_reg;
    logic [31:0]          frame_reg;
    logic [CHAN_BITS-1:0] chan_reg;
    logic                 read_reg;
    logic                 ta_reg;
    logic [15:0]          rd_reg;
    logic                 mdc_reg;
    logic                 out_reg;
    logic                 en_reg;
    logic                 cmd_ready_reg;
    logic                 rsp_valid_reg;
    logic [CHAN_BITS-1:0] rsp_chan_reg;
    logic [15:0]          rsp_data_reg;
    logic                 rsp_err_reg;

    logic                 cmd_is_read;
    logic                 cmd_bad;
    logic [31:0]          cmd_frame;
    logic                 tick_rise;
    logic                 tick_end;
    logic [NCHAN-1:0]     chan_hit;
    logic                 mdio_sel;

    // C45 reads are op 11 and 10 (read-increment); C22 read is op 10
    assign cmd_is_read = bus.cmd_c45 ? bus.cmd_op[1] : (bus.cmd_op == 2'b10);
    assign cmd_bad     = (bus.cmd_chan >= CHAN_BITS'(NCHAN)) ||
                         (!bus.cmd_c45 && (bus.cmd_op == 2'b00 || bus.cmd_op == 2'b11));
    // ST, OP, PHY, REG, TA=10, data; for reads only the first 14 bits go out
    assign cmd_frame   = {1'b0, !bus.cmd_c45, bus.cmd_op, bus.cmd_phy, bus.cmd_reg, 2'b10, bus.cmd_data};

    assign tick_rise = (cnt_reg == RISE_AT);
    assign tick_end  = (cnt_reg == END_AT);

    // Only the selected bus sees the shared serial engine; all others stay at 0
    genvar gi;
    generate
        for (gi = 0; gi < NCHAN; gi++) begin : g_chan
            assign chan_hit[gi] = (chan_reg == CHAN_BITS'(gi));
        end
    endgenerate

    assign mdio_sel      = |(bus.mdio_in & chan_hit);
    assign bus.mdc       = chan_hit & {NCHAN{mdc_reg}};
    assign bus.mdio_out  = chan_hit & {NCHAN{out_reg}};
    assign bus.mdio_en   = chan_hit & {NCHAN{en_reg}};
    assign bus.cmd_ready = cmd_ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_chan  = rsp_chan_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_err   = rsp_err_reg;

    // Command acceptance, MDC bit timing, frame sequencing and read capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_reg       <= '0;
            frame_reg     <= '0;
            chan_reg      <= '0;
            read_reg      <= 1'b0;
            ta_reg        <= 1'b0;
            rd_reg        <= '0;
            mdc_reg       <= 1'b0;
            out_reg       <= 1'b0;
            en_reg        <= 1'b0;
            cmd_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_chan_reg  <= '0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            rsp_valid_reg <= 1'b0;
            if (state_reg == IDLE) begin
                if (!cmd_ready_reg) begin
                    // one dead cycle after a rejected command
                    cmd_ready_reg <= 1'b1;
                end else if (bus.cmd_valid) begin
                    cmd_ready_reg <= 1'b0;
                    chan_reg      <= bus.cmd_chan;
                    read_reg      <= cmd_is_read;
                    if (cmd_bad) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b1;
                        rsp_data_reg  <= '0;
                        rsp_chan_reg  <= bus.cmd_chan;
                    end else begin
                        cnt_reg <= '0;
                        bit_reg <= '0;
                        mdc_reg <= 1'b0;
                        en_reg  <= 1'b1;
                        if (PREAMBLE_BITS > 0) begin
                            state_reg <= PRE;
                            out_reg   <= 1'b1;
                            frame_reg <= cmd_frame;
                        end else begin
                            state_reg <= FRAME;
                            out_reg   <= cmd_frame[31];
                            frame_reg <= {cmd_frame[30:0], 1'b0};
                        end
                    end
                end
            end else begin
                if (tick_rise && state_reg != END) begin
                    mdc_reg <= 1'b1;
                end
                if (tick_rise && state_reg == TA_RD && bit_reg == BIT_W'(1)) begin
                    ta_reg <= mdio_sel;
                end
                if (tick_rise && state_reg == DATA_RD) begin
                    rd_reg <= {rd_reg[14:0], mdio_sel};
                end
                if (!tick_end) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end else begin
                    // bit boundary: mdc falls and the next bit is launched
                    cnt_reg <= '0;
                    mdc_reg <= 1'b0;
                    bit_reg <= bit_reg + BIT_W'(1);
                    unique case (state_reg)
                        PRE: begin
                            if (bit_reg == PRE_LAST) begin
                                state_reg <= FRAME;
                                bit_reg   <= '0;
                                out_reg   <= frame_reg[31];
                                frame_reg <= {frame_reg[30:0], 1'b0};
                            end else begin
                                out_reg <= 1'b1;
                            end
                        end
                        FRAME: begin
                            if (read_reg && bit_reg == BIT_W'(13)) begin
                                state_reg <= TA_RD;
                                bit_reg   <= '0;
                                en_reg    <= 1'b0;
                                out_reg   <= 1'b0;
                            end else if (bit_reg == BIT_W'(31)) begin
                                state_reg <= END;
                                bit_reg   <= '0;
                                en_reg    <= 1'b0;
                                out_reg   <= 1'b0;
                            end else begin
                                out_reg   <= frame_reg[31];
                                frame_reg <= {frame_reg[30:0], 1'b0};
                            end
                        end
                        TA_RD: begin
                            if (bit_reg == BIT_W'(1)) begin
                                state_reg <= DATA_RD;
                                bit_reg   <= '0;
                            end
                        end
                        DATA_RD: begin
                            if (bit_reg == BIT_W'(15)) begin
                                state_reg <= END;
                                bit_reg   <= '0;
                            end
                        end
                        END: begin
                            state_reg     <= IDLE;
                            bit_reg       <= '0;
                            cmd_ready_reg <= 1'b1;
                            rsp_valid_reg <= 1'b1;
                            rsp_chan_reg  <= chan_reg;
                            rsp_data_reg  <= read_reg ? rd_reg : 16'h0000;
                            rsp_err_reg   <= read_reg & ta_reg;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: one instance with a 32-bit preamble, one without.
// Frames are predicted from the MDIO frame rules and compared bit by bit
// against what is seen on each mdc rising edge; a PHY model answers reads.
`timescale 1ns/1ps
module tb_mdio_master;
    localparam int HALF = 10;
    localparam int PER  = 2 * HALF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cv [2];
    logic [1:0]  c_chan;
    logic        c_c45;
    logic [1:0]  c_op;
    logic [4:0]  c_phy;
    logic [4:0]  c_reg;
    logic [15:0] c_data;
    logic [1:0]  min_v [2];

    int n_checks = 0;
    int n_errors = 0;

    mdio_master_if #(.NCHAN(2)) b0 ();
    mdio_master_if #(.NCHAN(2)) b1 ();

    assign b0.cmd_valid = cv[0];
    assign b1.cmd_valid = cv[1];
    assign b0.cmd_chan  = c_chan;
    assign b1.cmd_chan  = c_chan;
    assign b0.cmd_c45   = c_c45;
    assign b1.cmd_c45   = c_c45;
    assign b0.cmd_op    = c_op;
    assign b1.cmd_op    = c_op;
    assign b0.cmd_phy   = c_phy;
    assign b1.cmd_phy   = c_phy;
    assign b0.cmd_reg   = c_reg;
    assign b1.cmd_reg   = c_reg;
    assign b0.cmd_data  = c_data;
    assign b1.cmd_data  = c_data;
    assign b0.mdio_in   = min_v[0];
    assign b1.mdio_in   = min_v[1];

    mdio_master #(.HZ(50000000), .MDC_HZ(2500000), .NCHAN(2), .PREAMBLE_BITS(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0)
    );
    mdio_master #(.HZ(50000000), .MDC_HZ(2500000), .NCHAN(2), .PREAMBLE_BITS(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic peek(input int d, output logic [1:0] mdc, output logic [1:0] dout,
                        output logic [1:0] den, output logic rv, output logic re,
                        output logic [1:0] rc, output logic [15:0] rdat, output logic rdy);
        if (d == 0) begin
            mdc = b0.mdc; dout = b0.mdio_out; den = b0.mdio_en; rv = b0.rsp_valid;
            re = b0.rsp_err; rc = b0.rsp_chan; rdat = b0.rsp_data; rdy = b0.cmd_ready;
        end else begin
            mdc = b1.mdc; dout = b1.mdio_out; den = b1.mdio_en; rv = b1.rsp_valid;
            re = b1.rsp_err; rc = b1.rsp_chan; rdat = b1.rsp_data; rdy = b1.cmd_ready;
        end
    endtask

    // Target channel gets the PHY bit, the other channel the opposite level
    task automatic drive_in(input int d, input int ch, input logic b);
        min_v[d][ch]     = b;
        min_v[d][1 - ch] = ~b;
    endtask

    // What the PHY drives during mdc rise number r (counted from the first preamble bit)
    function automatic logic phy_bit(input int r, input int pre, input bit rd, input bit present,
                                     input logic ta, input logic [15:0] pd);
        if (!rd || !present) return 1'b1;
        if (r == pre + 15) return ta;
        if (r >= pre + 16 && r < pre + 32) return pd[15 - (r - pre - 16)];
        return 1'b1;
    endfunction

    task automatic randomize_fields();
        c_chan = 2'($urandom);
        c_c45  = 1'($urandom);
        c_op   = 2'($urandom);
        c_phy  = 5'($urandom);
        c_reg  = 5'($urandom);
        c_data = 16'($urandom);
    endtask

    task automatic run_txn(input int d, input logic [1:0] ch, input logic c45, input logic [1:0] op,
                           input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] data,
                           input bit present, input logic ta_val, input logic [15:0] pdata,
                           input bit noise);
        int          pre, chi, oth, n, lat, rises, viol, pre_ones;
        bit          rd;
        logic [31:0] exp_frame, mask, obs_frame, obs_en;
        logic [15:0] exp_data, rdat;
        logic        exp_err, rv, re, rdy, rdy_at, pmdc, pdout;
        logic [1:0]  mdc, dout, den, rc;

        pre       = (d == 0) ? 32 : 0;
        chi       = int'(ch);
        oth       = 1 - chi;
        rd        = c45 ? op[1] : (op == 2'b10);
        exp_frame = {1'b0, ~c45, op, phy, rg, 2'b10, rd ? 16'h0000 : data};
        mask      = rd ? 32'hFFFC_0000 : 32'hFFFF_FFFF;
        exp_data  = rd ? (present ? pdata : 16'hFFFF) : 16'h0000;
        exp_err   = rd && (present ? ta_val : 1'b1);

        @(negedge clk);
        peek(d, mdc, dout, den, rv, re, rc, rdat, rdy);
        check_val("ready_idle", 32'(rdy), 32'd1);
        c_chan = ch; c_c45 = c45; c_op = op; c_phy = phy; c_reg = rg; c_data = data;
        drive_in(d, chi, phy_bit(0, pre, rd, present, ta_val, pdata));
        cv[d] = 1'b1;
        @(posedge clk);
        #1;
        if (!noise) cv[d] = 1'b0;

        n = 0; lat = 0; rises = 0; viol = 0; pre_ones = 0;
        obs_frame = '0; obs_en = '0; pmdc = 1'b0; pdout = 1'b0; rdy_at = 1'b0;
        while (lat == 0 && n < 3000) begin
            @(negedge clk);
            n++;
            peek(d, mdc, dout, den, rv, re, rc, rdat, rdy);
            if (n == 1)
                check_val("first_bit", {mdc[chi], den[chi], dout[chi]}, {1'b0, 1'b1, pre > 0});
            else if (dout[chi] != pdout && !(pmdc && !mdc[chi]))
                viol++;
            if (mdc[oth] || dout[oth] || den[oth]) viol++;
            if (mdc[chi] && !pmdc) begin
                if (n != HALF + 1 + PER * rises) viol++;
                if (rises < pre) begin
                    pre_ones += int'(dout[chi] & den[chi]);
                end else if (rises < pre + 32) begin
                    obs_frame = {obs_frame[30:0], dout[chi]};
                    obs_en    = {obs_en[30:0], den[chi]};
                end
                rises++;
                drive_in(d, chi, phy_bit(rises, pre, rd, present, ta_val, pdata));
            end
            if (!mdc[chi] && pmdc && ((n - 1) % PER) != 0) viol++;
            if (rv) begin
                lat    = n;
                rdy_at = rdy;
                cv[d]  = 1'b0;
            end else begin
                if (rdy) viol++;
                if (noise) randomize_fields();
            end
            pmdc  = mdc[chi];
            pdout = dout[chi];
        end
        cv[d] = 1'b0;

        check_val("latency",   32'(lat),       32'((pre + 33) * PER + 1));
        check_val("rises",     32'(rises),     32'(pre + 32));
        check_val("preamble",  32'(pre_ones),  32'(pre));
        check_val("frame",     obs_frame & mask, exp_frame & mask);
        check_val("drive_en",  obs_en,         mask);
        check_val("rsp_data",  32'(rdat),      32'(exp_data));
        check_val("rsp_err",   32'(re),        32'(exp_err));
        check_val("rsp_chan",  32'(rc),        32'(ch));
        check_val("ready_back", 32'(rdy_at),   32'd1);
        check_val("bus_viol",  32'(viol),      32'd0);
        $display("TXN dut%0d ch=%0d c45=%0d op=%b phy=%h reg=%h wdata=%h noise=%0d -> rsp=%h err=%0d lat=%0d",
                 d, ch, c45, op, phy, rg, data, noise, rdat, re, lat);
    endtask

    task automatic run_bad(input int d, input logic [1:0] ch, input logic c45, input logic [1:0] op);
        int          act;
        logic [1:0]  mdc, dout, den, rc;
        logic [15:0] rdat;
        logic        rv, re, rdy;

        @(negedge clk);
        c_chan = ch; c_c45 = c45; c_op = op; c_phy = 5'($urandom); c_reg = 5'($urandom);
        c_data = 16'($urandom);
        cv[d] = 1'b1;
        @(posedge clk);
        #1;
        cv[d] = 1'b0;
        @(negedge clk);
        peek(d, mdc, dout, den, rv, re, rc, rdat, rdy);
        check_val("bad_rsp", {rv, re, rc, rdat, rdy}, {1'b1, 1'b1, ch, 16'h0000, 1'b0});
        act = int'(|{mdc, dout, den});
        @(negedge clk);
        peek(d, mdc, dout, den, rv, re, rc, rdat, rdy);
        check_val("bad_ready", {rv, rdy}, {1'b0, 1'b1});
        for (int k = 0; k < 60; k++) begin
            act += int'(|{mdc, dout, den});
            @(negedge clk);
            peek(d, mdc, dout, den, rv, re, rc, rdat, rdy);
        end
        check_val("bad_quiet", 32'(act), 32'd0);
        $display("TXN dut%0d reject ch=%0d c45=%0d op=%b", d, ch, c45, op);
    endtask

    initial begin
        logic [1:0]  mdc, dout, den, rc;
        logic [15:0] rdat;
        logic        rv, re, rdy;
        int          cnt;

        cv[0] = 1'b0; cv[1] = 1'b0;
        min_v[0] = 2'b11; min_v[1] = 2'b11;
        c_chan = '0; c_c45 = 1'b0; c_op = '0; c_phy = '0; c_reg = '0; c_data = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            peek(d, mdc, dout, den, rv, re, rc, rdat, rdy);
            check_val("reset_state", {rdy, rv, re, rc, rdat, mdc, dout, den},
                      {1'b1, 1'b0, 1'b0, 2'b00, 16'h0000, 6'b000000});
        end
        @(negedge clk);
        rst_n = 1'b1;

        // directed frames
        run_txn(0, 2'd1, 1'b0, 2'b01, 5'h03, 5'h1F, 16'hA55A, 1, 1'b0, 16'h0000, 0);
        run_txn(0, 2'd0, 1'b0, 2'b10, 5'h01, 5'h02, 16'h0000, 1, 1'b0, 16'h1234, 0);
        run_txn(0, 2'd0, 1'b0, 2'b10, 5'h01, 5'h02, 16'h0000, 0, 1'b0, 16'h0000, 0);
        run_txn(1, 2'd0, 1'b1, 2'b00, 5'h05, 5'h01, 16'h0010, 1, 1'b0, 16'h0000, 0);
        run_txn(1, 2'd0, 1'b1, 2'b11, 5'h05, 5'h01, 16'h0000, 1, 1'b0, 16'hBEEF, 0);
        run_txn(1, 2'd1, 1'b1, 2'b10, 5'h07, 5'h03, 16'h0000, 1, 1'b1, 16'h5A0F, 1);

        // rejected commands
        run_bad(0, 2'd2, 1'b0, 2'b01);
        run_bad(1, 2'd3, 1'b1, 2'b00);
        run_bad(0, 2'd1, 1'b0, 2'b00);
        run_bad(1, 2'd0, 1'b0, 2'b11);

        // reset in the middle of a preamble
        @(negedge clk);
        c_chan = 2'd0; c_c45 = 1'b0; c_op = 2'b01; c_phy = 5'h02; c_reg = 5'h04; c_data = 16'h1111;
        cv[0] = 1'b1;
        @(posedge clk);
        #1;
        cv[0] = 1'b0;
        repeat (100) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        peek(0, mdc, dout, den, rv, re, rc, rdat, rdy);
        check_val("rst_async", {mdc, den, dout, rv, rdy}, {6'b000000, 1'b0, 1'b1});
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 1400; k++) begin
            @(negedge clk);
            peek(0, mdc, dout, den, rv, re, rc, rdat, rdy);
            cnt += int'(rv) + int'(!rdy) + int'(|{mdc, den});
        end
        check_val("rst_no_rsp", 32'(cnt), 32'd0);

        // randomized traffic
        for (int i = 0; i < 16; i++) begin
            int          d;
            logic        c45;
            logic [1:0]  op;
            d   = int'($urandom_range(0, 1));
            c45 = 1'($urandom);
            op  = c45 ? 2'($urandom) : ($urandom_range(0, 1) == 0 ? 2'b01 : 2'b10);
            run_txn(d, 2'($urandom_range(0, 1)), c45, op, 5'($urandom), 5'($urandom),
                    16'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                    16'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mdio_master.md
MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 Parameter HZ, default 50000000: system clock frequency in Hz.
REQ-002 Parameter MDC_HZ, default 2500000: MDC frequency; HALF = HZ/MDC_HZ/2 SHALL be >= 2 (elaboration error otherwise).
REQ-003 Parameter NCHAN, default 2: number of MDIO buses; CHAN_BITS = $clog2(NCHAN+1).
REQ-004 Parameter PREAMBLE_BITS, default 32: preamble length in bits; 0 SHALL suppress the preamble.
REQ-005 clk  in  1  system clock, all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 cmd_valid  in  1  command request; cmd_ready  out  1  high only in IDLE; a command is accepted when both are high.
REQ-008 cmd_chan  in  CHAN_BITS  target bus; cmd_c45  in  1  1 = clause 45 frame, 0 = clause 22.
REQ-009 cmd_op  in  2  C22: 01 write, 10 read; C45: 00 address, 01 write, 11 read, 10 read-increment.
REQ-010 cmd_phy  in  5  PHY/port address; cmd_reg  in  5  register (C22) or DEVAD (C45); cmd_data  in  16  write data or C45 address.
REQ-011 rsp_valid  out  1  one-cycle completion pulse; rsp_chan  out  CHAN_BITS; rsp_data  out  16; rsp_err  out  1.
REQ-012 mdc  out  NCHAN; mdio_out  out  NCHAN; mdio_en  out  NCHAN  (1 = drive); mdio_in  in  NCHAN.

Function
REQ-013 All command fields SHALL be registered on acceptance; inputs are ignored outside acceptance.
REQ-014 States: IDLE, PRE, FRAME, TA_RD, DATA_RD, END; IDLE->PRE on accept (->FRAME if PREAMBLE_BITS=0).
REQ-015 A bit period SHALL be 2*HALF clocks: mdc low HALF clocks, then high HALF clocks; mdio_out changes only on the clock mdc falls (or the accept+1 cycle for bit 0).
REQ-016 The first bit SHALL be driven, with mdio_en=1, in the cycle after acceptance, with mdc low.
REQ-017 PRE SHALL send PREAMBLE_BITS ones.
REQ-018 FRAME SHALL send MSB first: ST (01 C22, 00 C45), OP, PHY, REG, TA, 16 data bits; 32 bits total.
REQ-019 Writes/address: TA = 10, data = cmd_data.
REQ-020 Reads: after OP/PHY/REG, mdio_en SHALL drop at the start of the first TA bit (TA_RD).
REQ-021 Reads: mdio_in SHALL be sampled on the clock mdc rises, for the second TA bit and for the 16 data bits (DATA_RD), shifted in MSB first.
REQ-022 A sampled second TA bit of 1 SHALL set rsp_err=1; the data is still returned.
REQ-023 END SHALL hold mdio_en=0, mdc low for one bit period, then pulse rsp_valid and return to IDLE in the same cycle.
REQ-024 rsp_data SHALL be 0 for writes/address and rsp_chan SHALL equal the accepted cmd_chan.
REQ-025 Transaction latency, accept to rsp_valid, SHALL be (PREAMBLE_BITS+33)*2*HALF+1 clocks for all ops.
REQ-026 cmd_chan >= NCHAN or an invalid C22 op (00/11): no bus activity; rsp_valid=1, rsp_err=1 the next cycle; cmd_ready returns the cycle after.
REQ-027 Unselected channels SHALL keep mdc=0, mdio_en=0, mdio_out=0 at all times.
REQ-028 cmd_valid during a transaction SHALL have no effect (cmd_ready=0).

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, mdc=0, mdio_out=0, mdio_en=0, rsp_valid=0, rsp_data=0, rsp_err=0, rsp_chan=0, bit/timing counters 0.
REQ-030 cmd_ready SHALL be 1 in reset and after it; a transaction interrupted by reset SHALL produce no rsp_valid.

Verification (HZ=50e6, MDC_HZ=2.5e6, HALF=10, NCHAN=2)
REQ-031 C22 write chan 1, phy 0x03, reg 0x1F, data 0xA55A -> ch1 mdio_out: 32 ones, 01 01 00011 11111 10 1010010101011010; ch0 idle; rsp_valid at accept+1301 clocks, err 0.
REQ-032 C22 read chan 0, phy 0x01, reg 0x02, PHY model drives TA 0 then 0x1234 -> mdio_en low from the TA bit, rsp_data 0x1234, rsp_err 0.
REQ-033 C22 read with mdio_in held 1 (absent PHY) -> rsp_data 0xFFFF, rsp_err 1.
REQ-034 PREAMBLE_BITS=0, C45 address (devad 1, data 0x0010) then read (op 11) -> no preamble, ST 00, OPs 00/11, read data returned, latency 661 clocks each.
REQ-035 cmd_chan=2 -> rsp_valid with rsp_err=1 the next cycle, no mdc toggles on any channel.
REQ-036 rst_n low mid-preamble -> mdc/mdio_en 0 in the same cycle, no rsp_valid, next command runs normally.
